status_handshake_tx: RTL and testbench

STATUS_HANDSHAKE_TX -- requirements
Module: status_handshake_tx

---
 rtl/status_handshake_tx.sv | 169 ++++++++++++++++
 tb/tb_status_handshake_tx.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/status_handshake_tx.sv
// Four-phase status transmitter: latches a code, drives it SETUP_CYCLES before req, completes on ack return.
// Latency: send -> data after 2 cycles, req SETUP_CYCLES later; ack passes a 2-flop synchronizer.
// Backpressure: sends while busy overwrite the pending code (latest wins); STATUS_TX_RETRY_EN enables timeout retries.
module status_handshake_tx #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_RETRIES    = 3,
    parameter int SETUP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] status_in,
    input  logic       send,
    input  logic       ack,
    output logic [3:0] data,
    output logic       req,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int ST_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETUP_CYCLES - 1);

`ifdef STATUS_TX_RETRY_EN
    localparam int RT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RT_W-1:0] RT_MAX = RT_W'(MAX_RETRIES);
    typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, RELEASE, BACKOFF} state_t;
    logic [RT_W-1:0] retry_cnt;
`else
    typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, RELEASE} state_t;
    logic unused_retries;
    assign unused_retries = (MAX_RETRIES != 0);
`endif

    state_t          state;
    logic            ack_m, ack_s;
    logic            pend_vld;
    logic [3:0]      pend_dat;
    logic [ST_W-1:0] setup_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            next_vld;
    logic [3:0]      next_dat;

    // A send arriving in the same cycle a code is consumed takes precedence, so nothing is lost.
    assign next_vld = send | pend_vld;
    assign next_dat = send ? status_in : pend_dat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack;
            ack_s <= ack_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data      <= 4'b0000;
            req       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            pend_vld  <= 1'b0;
            pend_dat  <= 4'b0000;
            setup_cnt <= '0;
            to_cnt    <= '0;
`ifdef STATUS_TX_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            busy  <= 1'b1;
            if (send) begin
                pend_dat <= status_in;
                pend_vld <= 1'b1;
            end
            case (state)
                IDLE: begin
                    busy <= next_vld;
                    if (pend_vld && !ack_s) begin
                        data      <= next_dat;
                        pend_vld  <= 1'b0;
                        setup_cnt <= '0;
                        state     <= SETUP;
`ifdef STATUS_TX_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                SETUP: begin
                    if (setup_cnt == ST_LAST) begin
                        req    <= 1'b1;
                        to_cnt <= '0;
                        state  <= REQ_HI;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req    <= 1'b0;
                        to_cnt <= '0;
                        state  <= RELEASE;
`ifdef STATUS_TX_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end else if (to_cnt == TO_LAST) begin
                        req <= 1'b0;
`ifdef STATUS_TX_RETRY_EN
                        if (retry_cnt != RT_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= BACKOFF;
                        end else begin
                            retry_cnt <= '0;
                            error     <= 1'b1;
                            busy      <= next_vld;
                            state     <= IDLE;
                        end
`else
                        error <= 1'b1;
                        busy  <= next_vld;
                        state <= IDLE;
`endif
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        done <= 1'b1;
                        if (next_vld) begin
                            data      <= next_dat;
                            pend_vld  <= 1'b0;
                            setup_cnt <= '0;
                            state     <= SETUP;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Receiver never released ack: drop the in-flight code, keep any newer one.
                        error <= 1'b1;
                        busy  <= next_vld;
                        state <= IDLE;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
`ifdef STATUS_TX_RETRY_EN
                BACKOFF: begin
                    if (!ack_s) begin
                        setup_cnt <= '0;
                        state     <= SETUP;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_status_handshake_tx.sv
// Directed bench for status_handshake_tx: cycle table for one transfer plus multi-cycle corner sequences.
module tb_status_handshake_tx;

    localparam int TO = 50;
`ifdef STATUS_TX_RETRY_EN
    localparam int EXP_RISES = 4;
    localparam int EXP_ERR_N = 212;
`else
    localparam int EXP_RISES = 1;
    localparam int EXP_ERR_N = 53;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] status_in;
    logic       send;
    logic       ack;
    logic       ack_man;
    logic       ack_resp = 1'b0;
    logic       resp_en;
    logic [3:0] data;
    logic       req, busy, done, error;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    assign ack = resp_en ? ack_resp : ack_man;

    status_handshake_tx #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(3), .SETUP_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .status_in (status_in),
        .send      (send),
        .ack       (ack),
        .data      (data),
        .req       (req),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Monitor: records the code on the link at every req rise, counts done/error pulses.
    int         done_cnt = 0;
    int         err_cnt  = 0;
    logic       req_prev = 1'b0;
    logic [3:0] rise_q[$];
    always @(negedge clk) begin
        if (req && !req_prev) rise_q.push_back(data);
        req_prev = req;
        if (done) done_cnt++;
        if (error) err_cnt++;
    end

    // Responder: raises ack a few cycles after req, drops it once req falls.
    int dly = 0;
    always @(negedge clk) begin
        if (!resp_en) begin
            ack_resp = 1'b0;
            dly = 0;
        end else if (req && !ack_resp) begin
            if (dly == 2) begin
                ack_resp = 1'b1;
                dly = 0;
            end else begin
                dly++;
            end
        end else if (!req && ack_resp) begin
            ack_resp = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return req;
            1: return !req;
            2: return !busy;
            3: return done;
            4: return error;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (cond(which)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic send_code(input logic [3:0] c);
        status_in = c;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    function automatic logic [3:0] rise_at(input int i);
        if (i < rise_q.size()) return rise_q[i];
        return 4'bxxxx;
    endfunction

    typedef struct {
        logic       snd;
        logic [3:0] st;
        logic       ak;
        logic [3:0] d;
        logic       rq;
        logic       bs;
        logic       dn;
        logic       er;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int n, bd, br, be;

        tbl[0]  = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b0; send = 1'b0; status_in = 4'b0000; ack_man = 1'b0; resp_en = 1'b0;
        #5;
        chk("rst_data", data, 4'b0000);
        chk("rst_req", req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        // Single transfer, cycle by cycle, with a hand-driven ack.
        for (int i = 0; i < 11; i++) begin
            send = tbl[i].snd;
            status_in = tbl[i].st;
            ack_man = tbl[i].ak;
            tick();
            chk($sformatf("tbl%0d_data", i), data, tbl[i].d);
            chk($sformatf("tbl%0d_req", i), req, tbl[i].rq);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bs);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].dn);
            chk($sformatf("tbl%0d_error", i), error, tbl[i].er);
        end
        send = 1'b0;
        tick();

        // New code sent while req is high follows the current one.
        resp_en = 1'b1;
        bd = done_cnt; br = rise_q.size();
        send_code(4'b0100);
        wait_for(0, 20, n);
        chk("a_req_seen", n > 0, 1'b1);
        send_code(4'b0000);
        wait_for(2, 200, n);
        chk("a_idle_seen", n > 0, 1'b1);
        tick();
        chk("a_done_cnt", done_cnt - bd, 2);
        chk("a_rise_cnt", rise_q.size() - br, 2);
        chk("a_rise0", rise_at(br), 4'b0100);
        chk("a_rise1", rise_at(br + 1), 4'b0000);

        // Several sends during one transfer: only the latest survives.
        bd = done_cnt; br = rise_q.size();
        send_code(4'b1000);
        wait_for(0, 20, n);
        chk("b_req_seen", n > 0, 1'b1);
        send_code(4'b0001);
        send_code(4'b0010);
        send_code(4'b0100);
        wait_for(2, 200, n);
        chk("b_idle_seen", n > 0, 1'b1);
        tick();
        chk("b_done_cnt", done_cnt - bd, 2);
        chk("b_rise_cnt", rise_q.size() - br, 2);
        chk("b_rise0", rise_at(br), 4'b1000);
        chk("b_rise1", rise_at(br + 1), 4'b0100);

        // Equal codes both sent; a send coinciding with done is not lost.
        bd = done_cnt; br = rise_q.size();
        send_code(4'b0100);
        wait_for(2, 200, n);
        send_code(4'b0100);
        wait_for(3, 40, n);
        chk("c_done_seen", n > 0, 1'b1);
        send_code(4'b0101);
        wait_for(2, 200, n);
        chk("c_idle_seen", n > 0, 1'b1);
        tick();
        chk("c_done_cnt", done_cnt - bd, 3);
        chk("c_rise_cnt", rise_q.size() - br, 3);
        chk("c_rise1", rise_at(br + 1), 4'b0100);
        chk("c_rise2", rise_at(br + 2), 4'b0101);
        resp_en = 1'b0;
        repeat (3) tick();

        // ack stuck high after release: abort with error, no done.
        ack_man = 1'b0;
        bd = done_cnt;
        send_code(4'b0110);
        wait_for(0, 20, n);
        ack_man = 1'b1;
        wait_for(1, 20, n);
        chk("d_release_seen", n > 0, 1'b1);
        wait_for(4, TO + 10, n);
        chk("d_error_seen", n > 0, 1'b1);
        chk("d_busy_low", busy, 1'b0);
        ack_man = 1'b0;
        repeat (4) tick();
        chk("d_no_done", done_cnt - bd, 0);

        // ack never arrives: timeout (and retries when enabled).
        bd = done_cnt; br = rise_q.size(); be = err_cnt;
        send_code(4'b0011);
        wait_for(4, 400, n);
        chk("e_error_tick", n, EXP_ERR_N);
        chk("e_req_low", req, 1'b0);
        chk("e_busy_low", busy, 1'b0);
        tick();
        chk("e_rise_cnt", rise_q.size() - br, EXP_RISES);
        chk("e_rise_last", rise_at(rise_q.size() - 1), 4'b0011);
        chk("e_err_cnt", err_cnt - be, 1);
        chk("e_no_done", done_cnt - bd, 0);

        // ack already high at send: wait in IDLE holding the code.
        ack_man = 1'b1;
        repeat (3) tick();
        bd = done_cnt; br = rise_q.size();
        send_code(4'b0100);
        repeat (5) tick();
        chk("f_req_held", req, 1'b0);
        chk("f_busy_held", busy, 1'b1);
        chk("f_no_rise", rise_q.size() - br, 0);
        ack_man = 1'b0;
        wait_for(0, 20, n);
        chk("f_req_seen", n > 0, 1'b1);
        chk("f_data", data, 4'b0100);
        ack_man = 1'b1;
        wait_for(1, 20, n);
        ack_man = 1'b0;
        wait_for(2, 20, n);
        tick();
        chk("f_done_cnt", done_cnt - bd, 1);

        // Reset during REQ_HI drops outputs at once; nothing resumes afterwards.
        send_code(4'b1001);
        wait_for(0, 20, n);
        chk("g_req_seen", n > 0, 1'b1);
        bd = done_cnt; br = rise_q.size();
        #2 reset = 1'b0;
        #1;
        chk("g_req_async", req, 1'b0);
        chk("g_busy_async", busy, 1'b0);
        chk("g_data_async", data, 4'b0000);
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        repeat (20) tick();
        chk("g_no_done", done_cnt - bd, 0);
        chk("g_no_rise", rise_q.size() - br, 0);
        chk("g_busy_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
